// File: rtl/led_matrix_scan.sv
// led_matrix_scan -- scan driver for a HUB75-style RGB LED panel.
//
// Walks col/row through the frame, samples the six colour bits the
// pixel generator returns combinationally for that coordinate, and
// shifts them into the panel with p_clk. After each row it blanks,
// latches the row, and optionally holds the display before the next row.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   enable                   run scanning (acted on at row boundaries)
//   r0_in..b1_in             pixel colour for current col/row (0 = upper, 1 = lower half)
//   col [6:0], row [3:0]     coordinate to the pixel generator
//   p_r0..p_b1               registered panel data
//   p_clk, p_lat, p_oe_n     panel shift clock, latch, output enable (active-low)
//   p_addr [3:0]             displayed row-pair address
//   frame_done               one-cycle pulse when the last row of a frame latches
module led_matrix_scan #(
   parameter int COLS      = 64,
   parameter int ROWS_HALF = 16,
   parameter int CLK_DIV   = 2,
   parameter int DISP_HOLD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       r0_in,
   input  logic       g0_in,
   input  logic       b0_in,
   input  logic       r1_in,
   input  logic       g1_in,
   input  logic       b1_in,
   output logic [6:0] col,
   output logic [3:0] row,
   output logic       p_r0,
   output logic       p_g0,
   output logic       p_b0,
   output logic       p_r1,
   output logic       p_g1,
   output logic       p_b1,
   output logic       p_clk,
   output logic       p_lat,
   output logic       p_oe_n,
   output logic [3:0] p_addr,
   output logic       frame_done
);

   localparam int              PH_W      = $clog2(2 * CLK_DIV);
   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_RISE   = PH_W'(CLK_DIV);
   localparam logic [PH_W-1:0] PH_ZERO   = {PH_W{1'b0}};
   localparam logic [6:0]      COL_LAST  = 7'(COLS - 1);
   localparam logic [3:0]      ROW_LAST  = 4'(ROWS_HALF - 1);
   localparam logic [7:0]      HOLD_LAST = 8'(DISP_HOLD - 1);
   localparam bit              HAS_HOLD  = (DISP_HOLD > 0);

   typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, HOLD} state_t;

   state_t          state_r, state_s;
   logic [PH_W-1:0] ph_r, ph_s;
   logic [7:0]      hold_r, hold_s;
   logic            shown_r, shown_s;
   logic [6:0]      col_s;
   logic [3:0]      row_s;
   logic [3:0]      addr_s;
   logic            lat_s;
   logic            done_s;
   logic            clk_s;
   logic            oe_s;
   logic            sample_s;

   // Next-state, counter and next-output computation.
   // Outputs are computed from the next state so that once registered they
   // describe the cycle the FSM is actually in.
   always_comb begin
      state_s = state_r;
      ph_s    = ph_r;
      hold_s  = hold_r;
      shown_s = shown_r;
      col_s   = col;
      row_s   = row;
      addr_s  = p_addr;
      lat_s   = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            ph_s  = PH_ZERO;
            col_s = 7'd0;
            if (enable) state_s = SHIFT;
            else        state_s = IDLE;
         end
         SHIFT: begin
            if (ph_r == PH_LAST) begin
               ph_s = PH_ZERO;
               if (col == COL_LAST) begin
                  col_s   = 7'd0;
                  state_s = BLANK;
               end else begin
                  col_s = col + 7'd1;
               end
            end else begin
               ph_s = ph_r + PH_W'(1);
            end
         end
         BLANK: begin
            // Row bookkeeping lands together with p_lat on the LATCH cycle.
            state_s = LATCH;
            lat_s   = 1'b1;
            addr_s  = row;
            shown_s = 1'b1;
            if (row == ROW_LAST) begin
               row_s  = 4'd0;
               done_s = 1'b1;
            end else begin
               row_s = row + 4'd1;
            end
         end
         LATCH: begin
            hold_s = 8'd0;
            if (HAS_HOLD)    state_s = HOLD;
            else if (enable) state_s = SHIFT;
            else             state_s = IDLE;
         end
         HOLD: begin
            if (hold_r == HOLD_LAST) begin
               hold_s = 8'd0;
               if (enable) state_s = SHIFT;
               else        state_s = IDLE;
            end else begin
               hold_s  = hold_r + 8'd1;
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
            ph_s    = PH_ZERO;
            col_s   = 7'd0;
         end
      endcase

      if ((state_s == SHIFT) && (ph_s >= PH_RISE)) clk_s = 1'b1;
      else                                         clk_s = 1'b0;

      // Previously latched row stays lit while the next one shifts in.
      case (state_s)
         SHIFT:   oe_s = ~shown_s;
         HOLD:    oe_s = 1'b0;
         default: oe_s = 1'b1;
      endcase

      if ((state_r == SHIFT) && (ph_r == PH_ZERO)) sample_s = 1'b1;
      else                                          sample_s = 1'b0;
   end

   // State, counters and control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         ph_r       <= PH_ZERO;
         hold_r     <= 8'd0;
         shown_r    <= 1'b0;
         col        <= 7'd0;
         row        <= 4'd0;
         p_addr     <= 4'd0;
         p_clk      <= 1'b0;
         p_lat      <= 1'b0;
         p_oe_n     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_r    <= state_s;
         ph_r       <= ph_s;
         hold_r     <= hold_s;
         shown_r    <= shown_s;
         col        <= col_s;
         row        <= row_s;
         p_addr     <= addr_s;
         p_clk      <= clk_s;
         p_lat      <= lat_s;
         p_oe_n     <= oe_s;
         frame_done <= done_s;
      end
   end

   // Panel data register: captures the generator's answer at the start of each column slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} <= 6'd0;
      end else if (sample_s) begin
         {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} <= {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed self-checking bench for led_matrix_scan (defaults, plus a DISP_HOLD = 5 instance).
module tb_led_matrix_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       en2 = 1'b0;
   logic       mode = 1'b0;
   logic       one = 1'b1;
   logic       r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
   logic [6:0] col;
   logic [3:0] row, p_addr;
   logic       p_r0, p_g0, p_b0, p_r1, p_g1, p_b1;
   logic       p_clk, p_lat, p_oe_n, frame_done;
   logic [6:0] col2;
   logic [3:0] row2, p_addr2;
   logic [5:0] d2;
   logic       p_clk2, p_lat2, p_oe_n2, frame_done2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Pixel generator model: constant pattern, or column-dependent bits in mode 1.
   assign r0_in = mode ? col[0] : 1'b1;
   assign g0_in = 1'b0;
   assign b0_in = 1'b1;
   assign r1_in = 1'b0;
   assign g1_in = 1'b1;
   assign b1_in = mode ? col[1] : 1'b0;

   led_matrix_scan dut (
      .clk(clk), .rst(rst), .enable(enable),
      .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
      .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
      .col(col), .row(row),
      .p_r0(p_r0), .p_g0(p_g0), .p_b0(p_b0),
      .p_r1(p_r1), .p_g1(p_g1), .p_b1(p_b1),
      .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n),
      .p_addr(p_addr), .frame_done(frame_done)
   );

   led_matrix_scan #(.DISP_HOLD(5)) dut2 (
      .clk(clk), .rst(rst), .enable(en2),
      .r0_in(one), .g0_in(one), .b0_in(one),
      .r1_in(one), .g1_in(one), .b1_in(one),
      .col(col2), .row(row2),
      .p_r0(d2[5]), .p_g0(d2[4]), .p_b0(d2[3]),
      .p_r1(d2[2]), .p_g1(d2[1]), .p_b1(d2[0]),
      .p_clk(p_clk2), .p_lat(p_lat2), .p_oe_n(p_oe_n2),
      .p_addr(p_addr2), .frame_done(frame_done2)
   );

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; en2 = 1'b0; mode = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({col, row, p_addr} !== 15'd0) begin
         errors++; $display("FAIL reset_addr: col=%0d row=%0d p_addr=%0d, expected 0 0 0", col, row, p_addr);
      end
      checks++;
      if ({p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} !== 6'd0) begin
         errors++; $display("FAIL reset_data: got %b, expected 000000", {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1});
      end
      checks++;
      if ({p_clk, p_lat, p_oe_n, frame_done} !== 4'b0010) begin
         errors++; $display("FAIL reset_ctrl: clk/lat/oe_n/done=%b, expected 0010", {p_clk, p_lat, p_oe_n, frame_done});
      end
      checks++;
      if ({p_clk2, p_lat2, p_oe_n2, frame_done2, col2, d2} !== {4'b0010, 7'd0, 6'd0}) begin
         errors++; $display("FAIL reset_dut2: ctrl=%b col=%0d data=%b, expected 0010 0 000000", {p_clk2, p_lat2, p_oe_n2, frame_done2}, col2, d2);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({p_oe_n, p_clk, p_lat, col} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
         errors++; $display("FAIL idle_after_reset: oe_n=%b clk=%b lat=%b col=%0d, expected 1 0 0 0", p_oe_n, p_clk, p_lat, col);
      end
   endtask

   task automatic test_const_data();
      int   rises;
      logic prev;
      rises = 0; prev = 1'b0;
      enable = 1'b1;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         if (p_clk === 1'b1 && prev === 1'b0) begin
            checks++;
            if (c != 2 + 4 * rises) begin
               errors++; $display("FAIL const_rise_time: rise %0d at cycle %0d, expected %0d", rises, c, 2 + 4 * rises);
            end
            checks++;
            if ({p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} !== 6'b101010) begin
               errors++; $display("FAIL const_data: rise %0d got %b, expected 101010", rises, {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1});
            end
            rises++;
         end
         prev = p_clk;
         checks++;
         if (p_oe_n !== 1'b1) begin
            errors++; $display("FAIL first_row_dark: cycle %0d oe_n=%b, expected 1", c, p_oe_n);
         end
      end
      checks++;
      if (rises != 64) begin
         errors++; $display("FAIL const_rise_count: got %0d, expected 64", rises);
      end
      @(negedge clk);
      checks++;
      if ({p_oe_n, p_clk, p_lat} !== 3'b100) begin
         errors++; $display("FAIL blank: oe_n/clk/lat=%b, expected 100", {p_oe_n, p_clk, p_lat});
      end
   endtask

   task automatic test_latch();
      @(negedge clk);
      checks++;
      if ({p_lat, p_oe_n, frame_done, p_addr, row} !== {3'b110, 4'd0, 4'd1}) begin
         errors++; $display("FAIL latch0: lat/oe_n/done=%b p_addr=%0d row=%0d, expected 110 0 1", {p_lat, p_oe_n, frame_done}, p_addr, row);
      end
      mode = 1'b1;
   endtask

   task automatic test_col_data();
      int         rises;
      logic       prev;
      logic [6:0] k;
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         if (p_clk === 1'b1 && prev === 1'b0) begin
            k = 7'(rises);
            checks++;
            if ({p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} !== {k[0], 4'b0101, k[1]}) begin
               errors++; $display("FAIL col_data: rise %0d got %b, expected %b", rises, {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1}, {k[0], 4'b0101, k[1]});
            end
            rises++;
         end
         prev = p_clk;
         checks++;
         if (p_oe_n !== 1'b0 || row !== 4'd1) begin
            errors++; $display("FAIL row1_shown: cycle %0d oe_n=%b row=%0d, expected 0 1", c, p_oe_n, row);
         end
      end
      checks++;
      if (rises != 64) begin
         errors++; $display("FAIL col_rise_count: got %0d, expected 64", rises);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({p_lat, p_addr, row} !== {1'b1, 4'd1, 4'd2}) begin
         errors++; $display("FAIL latch1: lat=%b p_addr=%0d row=%0d, expected 1 1 2", p_lat, p_addr, row);
      end
   endtask

   task automatic test_frame_wrap();
      int pulses;
      int lats;
      pulses = 0; lats = 0;
      for (int i = 0; i < 14 * 258; i++) begin
         @(negedge clk);
         if (p_lat === 1'b1) lats++;
         if (frame_done === 1'b1) begin
            pulses++;
            checks++;
            if (i != 14 * 258 - 1 || p_addr !== 4'd15 || row !== 4'd0 || p_lat !== 1'b1) begin
               errors++; $display("FAIL frame_done_ctx: cycle %0d p_addr=%0d row=%0d lat=%b, expected cycle %0d 15 0 1", i, p_addr, row, p_lat, 14 * 258 - 1);
            end
         end
      end
      checks++;
      if (pulses != 1 || lats != 14) begin
         errors++; $display("FAIL frame_pulses: frame_done=%0d latches=%0d, expected 1 14", pulses, lats);
      end
   endtask

   task automatic test_hold();
      en2 = 1'b1;
      for (int i = 0; i <= 520; i++) begin
         @(negedge clk);
         if (i == 255 || i == 256) begin
            checks++;
            if (p_oe_n2 !== 1'b1) begin
               errors++; $display("FAIL hold_dark: cycle %0d oe_n=%b, expected 1", i, p_oe_n2);
            end
         end
         if (i == 257 || i == 520) begin
            checks++;
            if ({p_lat2, p_oe_n2, p_addr2} !== {2'b11, (i == 257) ? 4'd0 : 4'd1}) begin
               errors++; $display("FAIL hold_latch: cycle %0d lat/oe_n=%b p_addr=%0d", i, {p_lat2, p_oe_n2}, p_addr2);
            end
         end
         if (i >= 258 && i <= 262) begin
            checks++;
            if ({p_oe_n2, p_lat2, p_clk2} !== 3'b000) begin
               errors++; $display("FAIL hold_state: cycle %0d oe_n/lat/clk=%b, expected 000", i, {p_oe_n2, p_lat2, p_clk2});
            end
         end
         if (i == 263) begin
            checks++;
            if ({p_oe_n2, p_clk2, col2, row2} !== {2'b00, 7'd0, 4'd1}) begin
               errors++; $display("FAIL hold_exit: oe_n=%b clk=%b col=%0d row=%0d, expected 0 0 0 1", p_oe_n2, p_clk2, col2, row2);
            end
         end
         if (i == 264 || i == 265) begin
            checks++;
            if (p_clk2 !== ((i == 265) ? 1'b1 : 1'b0)) begin
               errors++; $display("FAIL hold_first_rise: cycle %0d clk=%b", i, p_clk2);
            end
         end
      end
      en2 = 1'b0;
   endtask

   task automatic test_enable_drop();
      logic       found;
      logic [6:0] prev;
      logic [3:0] r;
      found = 1'b0; prev = col;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (col === 7'd30 && prev === 7'd29) found = 1'b1;
         prev = col;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL drop_timeout: col 30 not reached, got col=%0d", col);
      end
      r = row;
      enable = 1'b0;
      repeat (137) @(negedge clk);
      checks++;
      if ({p_lat, p_addr, row} !== {1'b1, r, r + 4'd1}) begin
         errors++; $display("FAIL drop_latch: lat=%b p_addr=%0d row=%0d, expected 1 %0d %0d", p_lat, p_addr, row, r, r + 4'd1);
      end
      @(negedge clk);
      checks++;
      if ({p_oe_n, p_clk, col} !== {2'b10, 7'd0}) begin
         errors++; $display("FAIL drop_idle: oe_n=%b clk=%b col=%0d, expected 1 0 0", p_oe_n, p_clk, col);
      end
      repeat (20) @(negedge clk);
      checks++;
      if ({p_oe_n, p_clk, p_lat, col, row} !== {3'b100, 7'd0, r + 4'd1}) begin
         errors++; $display("FAIL drop_stays_idle: oe_n=%b clk=%b lat=%b col=%0d row=%0d", p_oe_n, p_clk, p_lat, col, row);
      end
   endtask

   task automatic test_rst_mid();
      logic       found;
      logic [6:0] prev;
      found = 1'b0; prev = col;
      enable = 1'b1;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (col === 7'd10 && prev === 7'd9) found = 1'b1;
         prev = col;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rst_timeout: col 10 not reached, got col=%0d", col);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({p_clk, p_r0, p_b1} !== 3'b101) begin
         errors++; $display("FAIL pre_rst: clk/r0/b1=%b, expected 101", {p_clk, p_r0, p_b1});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({col, row, p_addr, p_r0, p_g0, p_b0, p_r1, p_g1, p_b1, p_clk, p_lat, p_oe_n, frame_done} !== {15'd0, 6'd0, 4'b0010}) begin
         errors++; $display("FAIL async_rst: col=%0d row=%0d addr=%0d data=%b ctrl=%b", col, row, p_addr, {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1}, {p_clk, p_lat, p_oe_n, frame_done});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({col, row, p_oe_n, p_clk} !== {7'd0, 4'd0, 2'b10}) begin
         errors++; $display("FAIL restart: col=%0d row=%0d oe_n=%b clk=%b, expected 0 0 1 0", col, row, p_oe_n, p_clk);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({p_clk, p_r0, p_b1, p_oe_n} !== 4'b1001) begin
         errors++; $display("FAIL restart_rise: clk/r0/b1/oe_n=%b, expected 1001", {p_clk, p_r0, p_b1, p_oe_n});
      end
   endtask

   initial begin
      test_reset();
      test_const_data();
      test_latch();
      test_col_data();
      test_frame_wrap();
      test_hold();
      test_enable_drop();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
